// File: rtl/jesd204b_tx_link.sv
// JESD204B TX link layer: CGS / ILAS / DATA sequencing per lane under SYNC~ and LMFC; optional JESD_TX_SCRAMBLER_EN.
// Outputs registered one cycle behind state/counters; no backpressure, tx_ready_o high for every DATA cycle.
module jesd204b_tx_link #(
  parameter int L               = 2,
  parameter int PARALLEL_OCTETS = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int F               = 4,
  parameter int K               = 8,
  parameter int ILAS_MF         = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            sync_ni,
  input  logic                            lmfc_edge_i,
  input  logic [111:0]                    cfg_octets_i,
  input  logic [L*DATA_WIDTH-1:0]         tx_data_i,
  output logic                            tx_ready_o,
  output logic [L*DATA_WIDTH-1:0]         tx_data_o,
  output logic [L*PARALLEL_OCTETS-1:0]    tx_charisk_o,
  output logic [1:0]                      link_state_o
);

  localparam int N            = F * K;
  localparam int BEATS_PER_MF = N / PARALLEL_OCTETS;
  localparam int BW           = $clog2(BEATS_PER_MF);
  localparam int MW           = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_MF - 1);
  localparam logic [MW-1:0] MF_LAST   = MW'(ILAS_MF - 1);
  localparam logic [MW-1:0] MF_CFG    = MW'(1);

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic                         sync_meta_q, sync_meta_d;
  logic                         sync_q, sync_d;
  logic [1:0]                   state_q, state_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [MW-1:0]                mf_q, mf_d;
  logic [L*DATA_WIDTH-1:0]      data_q, data_d;
  logic [L*PARALLEL_OCTETS-1:0] charisk_q, charisk_d;
  logic [L*DATA_WIDTH-1:0]      payload;

  always_comb begin
    sync_meta_d = sync_ni;
    sync_d      = sync_meta_q;
    beat_d      = (lmfc_edge_i || beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
    state_d     = state_q;
    mf_d        = mf_q;
    case (state_q)
      ST_CGS: begin
        if (lmfc_edge_i && sync_q) begin
          state_d = ST_ILAS;
          mf_d    = '0;
        end
      end
      ST_ILAS: begin
        // loss of SYNC~ wins over a coincident LMFC edge
        if (!sync_q) begin
          state_d = ST_CGS;
        end else if (lmfc_edge_i) begin
          if (mf_q == MF_LAST) state_d = ST_DATA;
          else                 mf_d    = mf_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (!sync_q) state_d = ST_CGS;
      end
      default: state_d = ST_CGS;
    endcase
  end

`ifdef JESD_TX_SCRAMBLER_EN
  localparam logic [14:0] SCR_SEED = 15'h7F80;
  logic [L-1:0][14:0] scr_q, scr_d;

  // 1 + x^14 + x^15 self-synchronous, octet 0 first, MSB first; reseeded whenever not in DATA
  always_comb begin
    logic [14:0] st;
    logic        s;
    st      = '0;
    s       = 1'b0;
    payload = '0;
    scr_d   = scr_q;
    for (int l = 0; l < L; l++) begin
      st = scr_q[l];
      for (int o = 0; o < PARALLEL_OCTETS; o++) begin
        for (int b = 7; b >= 0; b--) begin
          s  = tx_data_i[l*DATA_WIDTH + o*8 + b] ^ st[14] ^ st[13];
          payload[l*DATA_WIDTH + o*8 + b] = s;
          st = {st[13:0], s};
        end
      end
      scr_d[l] = (state_q == ST_DATA) ? st : SCR_SEED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) scr_q <= {L{SCR_SEED}};
    else         scr_q <= scr_d;
  end
`else
  always_comb payload = tx_data_i;
`endif

  always_comb begin
    int          idx;
    logic [7:0]  oct;
    logic        kc;
    idx       = 0;
    oct       = 8'hBC;
    kc        = 1'b1;
    data_d    = '0;
    charisk_d = '0;
    for (int l = 0; l < L; l++) begin
      for (int o = 0; o < PARALLEL_OCTETS; o++) begin
        idx = int'(beat_q) * PARALLEL_OCTETS + o;
        oct = 8'hBC;
        kc  = 1'b1;
        if (state_q == ST_ILAS) begin
          if (idx == 0) begin
            oct = 8'h1C;
          end else if (idx == N - 1) begin
            oct = 8'h7C;
          end else if (mf_q == MF_CFG && idx == 1) begin
            oct = 8'h9C;
          end else if (mf_q == MF_CFG && idx >= 2 && idx <= 15) begin
            oct = cfg_octets_i[(idx-2)*8 +: 8];
            if (idx == 3) oct[4:0] = 5'(l);
            kc  = 1'b0;
          end else begin
            oct = 8'(idx);
            kc  = 1'b0;
          end
        end else if (state_q == ST_DATA) begin
          oct = payload[l*DATA_WIDTH + o*8 +: 8];
          kc  = 1'b0;
        end
        data_d[l*DATA_WIDTH + o*8 +: 8]    = oct;
        charisk_d[l*PARALLEL_OCTETS + o]   = kc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= ST_CGS;
      beat_q      <= '0;
      mf_q        <= '0;
      data_q      <= {(L*PARALLEL_OCTETS){8'hBC}};
      charisk_q   <= '1;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      beat_q      <= beat_d;
      mf_q        <= mf_d;
      data_q      <= data_d;
      charisk_q   <= charisk_d;
    end
  end

  assign tx_ready_o   = (state_q == ST_DATA);
  assign link_state_o = state_q;
  assign tx_data_o    = data_q;
  assign tx_charisk_o = charisk_q;

endmodule

// File: tb/tb_jesd204b_tx_link.sv
// Scoreboarded bench for jesd204b_tx_link: expected outputs are queued per cycle, a negedge monitor compares.
module tb_jesd204b_tx_link;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         sync_ni;
  logic         lmfc_edge_i;
  logic [111:0] cfg_octets_i;
  logic [63:0]  tx_data_i;
  logic         tx_ready_o;
  logic [63:0]  tx_data_o;
  logic [7:0]   tx_charisk_o;
  logic [1:0]   link_state_o;

  jesd204b_tx_link dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .sync_ni      (sync_ni),
    .lmfc_edge_i  (lmfc_edge_i),
    .cfg_octets_i (cfg_octets_i),
    .tx_data_i    (tx_data_i),
    .tx_ready_o   (tx_ready_o),
    .tx_data_o    (tx_data_o),
    .tx_charisk_o (tx_charisk_o),
    .link_state_o (link_state_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [63:0] dat;
    logic [7:0]  k;
    logic [1:0]  st;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [63:0] BC64 = 64'hBCBCBCBC_BCBCBCBC;

  // cycle counter and free-running LMFC: edge pulse during every cycle with cyc % 8 == 0
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    lmfc_edge_i = (cyc % 8 == 0);
  end

  task automatic push(input int c, input logic [63:0] d, input logic [7:0] k,
                      input logic [1:0] st, input logic rdy);
    exp_t e;
    e.cyc = c; e.dat = d; e.k = k; e.st = st; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  task automatic push_cgs(input int c);
    push(c, BC64, 8'hFF, 2'd0, 1'b0);
  endtask

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, req);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  always @(negedge clk_i) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        chk("missed_slot", cyc, 64'(e.cyc), 64'(cyc));
      end else begin
        chk("tx_data",    cyc, tx_data_o, e.dat);
        chk("charisk",    cyc, 64'(tx_charisk_o), 64'(e.k));
        chk("link_state", cyc, 64'(link_state_o), 64'(e.st));
        chk("tx_ready",   cyc, 64'(tx_ready_o), 64'(e.rdy));
      end
    end
  end

`ifdef JESD_TX_SCRAMBLER_EN
  logic [14:0] mst0 = 15'h7F80;
  logic [14:0] mst1 = 15'h7F80;

  function automatic logic [31:0] scr32(input logic [31:0] d, inout logic [14:0] st);
    logic [31:0] r;
    logic        s;
    r = '0;
    for (int o = 0; o < 4; o++) begin
      for (int b = 7; b >= 0; b--) begin
        s = d[o*8+b] ^ st[14] ^ st[13];
        r[o*8+b] = s;
        st = {st[13:0], s};
      end
    end
    return r;
  endfunction
`endif

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] l0, l1;
    rst_ni      = 1'b1;
    sync_ni     = 1'b0;
    lmfc_edge_i = 1'b0;
    tx_data_i   = '0;
    for (int n = 2; n <= 15; n++) cfg_octets_i[(n-2)*8 +: 8] = 8'(n * 17);
    #1 rst_ni = 1'b0;

    push_cgs(2);
    goto(4);
    rst_ni = 1'b1;
    for (int c = 5; c <= 54; c++) push_cgs(c);

    // SYNC~ raised 5 cycles before the edge driven in cycle 64
    goto(59);
    sync_ni = 1'b1;
    push_cgs(64);
    push(65, BC64,                    8'hFF, 2'd1, 1'b0);
    push(66, 64'h0302011C_0302011C,   8'h11, 2'd1, 1'b0);
    push(67, 64'h07060504_07060504,   8'h00, 2'd1, 1'b0);
    push(73, 64'h7C1E1D1C_7C1E1D1C,   8'h88, 2'd1, 1'b0);
    push(74, 64'h21229C1C_20229C1C,   8'h33, 2'd1, 1'b0);
    push(75, 64'h77665544_77665544,   8'h00, 2'd1, 1'b0);
    push(76, 64'hBBAA9988_BBAA9988,   8'h00, 2'd1, 1'b0);
    push(77, 64'hFFEEDDCC_FFEEDDCC,   8'h00, 2'd1, 1'b0);
    push(78, 64'h13121110_13121110,   8'h00, 2'd1, 1'b0);
    push(82, 64'h0302011C_0302011C,   8'h11, 2'd1, 1'b0);
    push(90, 64'h0302011C_0302011C,   8'h11, 2'd1, 1'b0);
    push(97, 64'h7C1E1D1C_7C1E1D1C,   8'h88, 2'd2, 1'b1);

    // DATA: beat k driven in cycle 97+k, seen on the output after posedge 98+k
    for (int k = 0; k <= 13; k++) begin
      goto(97 + k);
`ifdef JESD_TX_SCRAMBLER_EN
      l0 = 32'h0;
      l1 = 32'h0;
`else
      l0 = 32'h1000_0000 + 32'(k);
      l1 = 32'h2000_0000 + 32'(k);
`endif
      tx_data_i = {l1, l0};
      if (k == 8) sync_ni = 1'b0;
      if (k <= 10) begin
`ifdef JESD_TX_SCRAMBLER_EN
        l0 = scr32(l0, mst0);
        l1 = scr32(l1, mst1);
`endif
        push(98 + k, {l1, l0}, 8'h00, (k <= 9) ? 2'd2 : 2'd0, (k <= 9));
      end else begin
        push_cgs(98 + k);
      end
    end

    // SYNC~ back high after the cycle-112 edge: must wait for the cycle-120 edge
    goto(113);
    sync_ni   = 1'b1;
    tx_data_i = '0;
    for (int c = 114; c <= 120; c++) push_cgs(c);
    push(121, BC64,                  8'hFF, 2'd1, 1'b0);
    push(122, 64'h0302011C_0302011C, 8'h11, 2'd1, 1'b0);
    push(124, 64'h0B0A0908_0B0A0908, 8'h00, 2'd1, 1'b0);
    push_cgs(125);

    // reset asserted between clock edges, checked before the next posedge
    goto(125);
    #2 rst_ni = 1'b0;
    goto(127);
    rst_ni = 1'b1;
    push_cgs(128);

    goto(131);
    chk("queue_drained", cyc, 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
